// File: rtl/align_seq_if.sv
// Handshake and control bundle between the alignment sequencer and its host.
// The master drives job requests and traceback coordinates, the slave returns control strobes.
interface align_seq_if #(
    parameter int SEQ_LEN     = 32,
    parameter int LPU         = 2,
    parameter int LOAD_CYCLES = 8
);
    localparam int NUM_PU    = SEQ_LEN / LPU;
    localparam int NUM_WAVES = 2 * NUM_PU - 1;
    localparam int POS_W     = $clog2(SEQ_LEN);
    localparam int WAVE_W    = $clog2(NUM_WAVES);
    localparam int BC_W      = $clog2(LOAD_CYCLES);
    localparam int PU_W      = $clog2(NUM_PU);
    localparam int PE_W      = 2 * $clog2(LPU);

    logic              start;
    logic              abort;
    logic              tb_finished;
    logic              out_ready;
    logic [POS_W-1:0]  tb_row;
    logic [POS_W-1:0]  tb_col;

    logic              ready;
    logic              busy;
    logic              buff_wr_en;
    logic [BC_W-1:0]   buff_count;
    logic [NUM_PU-1:0] pu_wr_en;
    logic [WAVE_W-1:0] wave_idx;
    logic              max_wr_en;
    logic              tb_en;
    logic              tb_start;
    logic              result_valid;
    logic [WAVE_W-1:0] mem_diag;
    logic [PU_W-1:0]   mem_pu;
    logic [PE_W-1:0]   mem_pe;

    modport master (
        output start, abort, tb_finished, out_ready, tb_row, tb_col,
        input  ready, busy, buff_wr_en, buff_count, pu_wr_en, wave_idx,
               max_wr_en, tb_en, tb_start, result_valid, mem_diag, mem_pu, mem_pe
    );

    modport slave (
        input  start, abort, tb_finished, out_ready, tb_row, tb_col,
        output ready, busy, buff_wr_en, buff_count, pu_wr_en, wave_idx,
               max_wr_en, tb_en, tb_start, result_valid, mem_diag, mem_pu, mem_pe
    );
endinterface

// File: rtl/align_seq_controller.sv
// Job sequencer for a systolic sequence aligner: load, anti-diagonal sweep, drain,
// traceback and result hand-off, plus the traceback-to-matrix-memory address map.
module align_seq_controller #(
    parameter int SEQ_LEN     = 32,
    parameter int LPU         = 2,
    parameter int LOAD_CYCLES = 8,
    parameter int PIPE_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst,
    align_seq_if.slave  bus
);
    localparam int NUM_PU    = SEQ_LEN / LPU;
    localparam int NUM_WAVES = 2 * NUM_PU - 1;
    localparam int POS_W     = $clog2(SEQ_LEN);
    localparam int WAVE_W    = $clog2(NUM_WAVES);
    localparam int BC_W      = $clog2(LOAD_CYCLES);
    localparam int PU_W      = $clog2(NUM_PU);
    localparam int LPU_W     = $clog2(LPU);

    localparam int CNT_TOP_A = (LOAD_CYCLES > NUM_WAVES) ? LOAD_CYCLES : NUM_WAVES;
    localparam int CNT_MAX   = ((CNT_TOP_A > PIPE_LAT) ? CNT_TOP_A : PIPE_LAT) - 1;
    localparam int CNT_W     = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAVE_LAST  = CNT_W'(NUM_WAVES - 1);
    localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CALC  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_TRACE = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tb_first_q, tb_first_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        tb_first_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                end
            end
            ST_LOAD: begin
                if (cnt_q == LOAD_LAST) begin
                    state_d = ST_CALC;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_CALC: begin
                if (cnt_q == WAVE_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d    = ST_TRACE;
                    cnt_d      = '0;
                    tb_first_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_TRACE: begin
                if (bus.tb_finished) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Abort overrides every transition above, but an idle controller ignores it.
        if (bus.abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            tb_first_d = 1'b0;
        end
    end

    // NOTE: state registers take non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            tb_first_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tb_first_q <= tb_first_d;
        end
    end

    logic [NUM_PU-1:0] pu_mask;
    int                wave;

    // Active PUs grow by one per wave up to the main diagonal, then shrink from the top.
    always_comb begin
        pu_mask = '0;
        wave    = int'(cnt_q);
        if (state_q == ST_CALC) begin
            for (int i = 0; i < NUM_PU; i++) begin
                pu_mask[i] = (wave < NUM_PU) ? (i <= wave) : (i < NUM_WAVES - wave);
            end
        end
    end

    assign bus.ready        = (state_q == ST_IDLE);
    assign bus.busy         = (state_q == ST_LOAD) || (state_q == ST_CALC) || (state_q == ST_DRAIN);
    assign bus.buff_wr_en   = (state_q == ST_LOAD);
    assign bus.buff_count   = (state_q == ST_LOAD) ? BC_W'(cnt_q) : '0;
    assign bus.pu_wr_en     = pu_mask;
    assign bus.wave_idx     = (state_q == ST_CALC) ? WAVE_W'(cnt_q) : '0;
    assign bus.max_wr_en    = (state_q == ST_CALC) || (state_q == ST_DRAIN);
    assign bus.tb_en        = (state_q == ST_TRACE);
    assign bus.tb_start     = (state_q == ST_TRACE) && tb_first_q;
    assign bus.result_valid = (state_q == ST_DONE);

    logic [PU_W-1:0]   row_blk, col_blk;
    logic [WAVE_W-1:0] diag;

    assign row_blk = bus.tb_row[POS_W-1:LPU_W];
    assign col_blk = bus.tb_col[POS_W-1:LPU_W];
    assign diag    = WAVE_W'(row_blk) + WAVE_W'(col_blk);

    // Below the main diagonal the column block names the PU; above it the row block counts down.
    assign bus.mem_diag = diag;
    assign bus.mem_pu   = (diag < WAVE_W'(NUM_PU)) ? col_blk : (PU_W'(NUM_PU - 1) - row_blk);
    assign bus.mem_pe   = {bus.tb_row[LPU_W-1:0], bus.tb_col[LPU_W-1:0]};
endmodule

// File: tb/tb_align_seq_controller.sv
// Self-checking bench: default build against a timeline reference model, plus a
// SEQ_LEN=64/LPU=4 build for the reparametrised sweep and mid-trace reset.
module tb_align_seq_controller;
    localparam int L   = 8;
    localparam int NP  = 16;
    localparam int W   = 2 * NP - 1;
    localparam int P   = 1;
    localparam int PRE = L + W + P;

    logic clk;
    logic rst;
    logic rst1;
    int   checks;
    int   errors;

    // Model: m_age counts cycles since job acceptance (0 = idle); m_done marks the result phase.
    int m_age;
    bit m_done;

    align_seq_if bus0 ();
    align_seq_if #(.SEQ_LEN(64), .LPU(4), .LOAD_CYCLES(8)) bus1 ();

    align_seq_controller dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    align_seq_controller #(.SEQ_LEN(64), .LPU(4), .LOAD_CYCLES(8), .PIPE_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (bus1.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [30:0] obs0();
        return {bus0.ready, bus0.busy, bus0.buff_wr_en, bus0.buff_count, bus0.pu_wr_en,
                bus0.wave_idx, bus0.max_wr_en, bus0.tb_en, bus0.tb_start, bus0.result_valid};
    endfunction

    function automatic logic [30:0] exp_vec();
        logic idle, load, calc, drain, trace;
        logic [2:0]  bc;
        logic [15:0] pu;
        logic [4:0]  wv;
        int w, n_act;
        idle  = (m_age == 0);
        load  = (m_age >= 1) && (m_age <= L);
        calc  = (m_age > L) && (m_age <= L + W);
        drain = (m_age > L + W) && (m_age <= PRE);
        trace = (m_age > PRE) && !m_done;
        w     = m_age - L - 1;
        bc    = load ? 3'(m_age - 1) : 3'd0;
        wv    = calc ? 5'(w) : 5'd0;
        n_act = (w < NP) ? w + 1 : W - w;
        pu    = calc ? 16'((32'd1 << n_act) - 32'd1) : 16'd0;
        return {idle, load | calc | drain, load, bc, pu, wv, calc | drain, trace,
                trace && (m_age == PRE + 1), m_done};
    endfunction

    task automatic model_step();
        if (rst) begin
            m_age = 0; m_done = 0;
        end else if (m_age == 0) begin
            if (bus0.start) m_age = 1;
        end else if (bus0.abort) begin
            m_age = 0; m_done = 0;
        end else if (m_done) begin
            if (bus0.out_ready) begin m_age = 0; m_done = 0; end
        end else if (m_age > PRE && bus0.tb_finished) begin
            m_done = 1;
        end else begin
            m_age++;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus0.start = 0; bus0.abort = 0; bus0.tb_finished = 0; bus0.out_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; rst1 = 1;
        bus0.start = 1; bus0.abort = 1; bus0.tb_finished = 1; bus0.out_ready = 1;
        step(); step();
        checks++;
        if (obs0() !== 31'h4000_0000) begin
            errors++; $display("FAIL reset_state got=%h exp=%h", obs0(), 31'h4000_0000);
        end
        rst = 0; rst1 = 0; clear_inputs();
        bus0.start = 1; step(); bus0.start = 0;
        repeat (15) step();
        checks++;
        if (bus0.max_wr_en !== 1'b1) begin
            errors++; $display("FAIL reset_pre_calc got=%b exp=1", bus0.max_wr_en);
        end
        rst = 1; step(); rst = 0;
        checks++;
        if (obs0() !== 31'h4000_0000 || obs0() !== exp_vec()) begin
            errors++; $display("FAIL reset_mid_job got=%h exp=%h", obs0(), 31'h4000_0000);
        end
    endtask

    task automatic test_nominal();
        bus0.start = 1; step(); bus0.start = 0;
        for (int n = 1; n <= 49; n++) begin
            checks++;
            if (obs0() !== exp_vec()) begin
                errors++; $display("FAIL nominal_model cyc=%0d got=%h exp=%h", n, obs0(), exp_vec());
            end
            checks++;
            if (bus0.buff_wr_en !== (n >= 1 && n <= 8) ||
                (n <= 8 && bus0.buff_count !== 3'(n - 1))) begin
                errors++; $display("FAIL nominal_load cyc=%0d got=%b/%0d", n, bus0.buff_wr_en, bus0.buff_count);
            end
            checks++;
            if (bus0.tb_start !== (n == 41) || bus0.result_valid !== (n >= 46 && n <= 48) ||
                bus0.ready !== (n == 49)) begin
                errors++; $display("FAIL nominal_ctrl cyc=%0d got=%b%b%b", n, bus0.tb_start, bus0.result_valid, bus0.ready);
            end
            if (n == 9 || n == 24 || n == 25 || n == 39) begin
                logic [15:0] want;
                want = (n == 24) ? 16'hFFFF : (n == 25) ? 16'h7FFF : 16'h0001;
                checks++;
                if (bus0.pu_wr_en !== want || bus0.wave_idx !== 5'(n - 9)) begin
                    errors++; $display("FAIL pu_sweep cyc=%0d got=%h/%0d exp=%h/%0d", n, bus0.pu_wr_en, bus0.wave_idx, want, n - 9);
                end
            end
            bus0.tb_finished = (n == 45);
            bus0.out_ready   = (n == 48);
            if (n < 49) step();
        end
        clear_inputs();
    endtask

    task automatic run_job(input int fin_delay, input int rdy_delay, input bit stray, input string tag);
        int tr, dn;
        tr = 0; dn = 0;
        bus0.start = 1; step(); bus0.start = 0;
        for (int n = 1; n < 400; n++) begin
            checks++;
            if (obs0() !== exp_vec()) begin
                errors++; $display("FAIL %s cyc=%0d got=%h exp=%h", tag, n, obs0(), exp_vec());
            end
            if (m_done) begin
                checks++;
                if (bus0.result_valid !== 1'b1) begin
                    errors++; $display("FAIL %s_hold cyc=%0d got=%b exp=1", tag, n, bus0.result_valid);
                end
            end
            clear_inputs();
            if (m_age == 0) break;
            if (stray && m_age >= 2 && m_age <= 5) begin
                bus0.start = 1; bus0.tb_finished = 1;
            end
            if (m_done) begin
                if (dn == rdy_delay) bus0.out_ready = 1;
                dn++;
            end else if (m_age > PRE) begin
                if (tr == fin_delay) bus0.tb_finished = 1;
                tr++;
            end
            step();
        end
        clear_inputs();
        checks++;
        if (bus0.ready !== 1'b1) begin
            errors++; $display("FAIL %s_end got=%b exp=1", tag, bus0.ready);
        end
    endtask

    task automatic test_abort();
        bus0.start = 1; step(); bus0.start = 0;
        repeat (18) step();
        checks++;
        if (bus0.wave_idx !== 5'd10) begin
            errors++; $display("FAIL abort_wave got=%0d exp=10", bus0.wave_idx);
        end
        bus0.abort = 1; step(); bus0.abort = 0;
        checks++;
        if (bus0.ready !== 1'b1 || bus0.pu_wr_en !== 16'h0 || bus0.max_wr_en !== 1'b0 || obs0() !== exp_vec()) begin
            errors++; $display("FAIL abort_idle got=%h exp=%h", obs0(), exp_vec());
        end
        bus0.abort = 1; step(); bus0.abort = 0;
        checks++;
        if (bus0.ready !== 1'b1) begin
            errors++; $display("FAIL abort_in_idle got=%b exp=1", bus0.ready);
        end
        run_job(4, 2, 0, "abort_restart");
    endtask

    task automatic test_mem_select();
        bus0.tb_row = 5; bus0.tb_col = 6; bus1.tb_row = 5; bus1.tb_col = 6; #1;
        checks++;
        if (bus0.mem_diag !== 5'd5 || bus0.mem_pu !== 4'd3 || bus0.mem_pe !== 2'b10) begin
            errors++; $display("FAIL mem_5_6 got=%0d/%0d/%b exp=5/3/10", bus0.mem_diag, bus0.mem_pu, bus0.mem_pe);
        end
        checks++;
        if (bus1.mem_diag !== 5'd2 || bus1.mem_pu !== 4'd1 || bus1.mem_pe !== 4'b0110) begin
            errors++; $display("FAIL mem64_5_6 got=%0d/%0d/%b exp=2/1/0110", bus1.mem_diag, bus1.mem_pu, bus1.mem_pe);
        end
        bus0.tb_row = 31; bus0.tb_col = 30; bus1.tb_row = 63; bus1.tb_col = 62; #1;
        checks++;
        if (bus0.mem_diag !== 5'd30 || bus0.mem_pu !== 4'd0 || bus0.mem_pe !== 2'b10) begin
            errors++; $display("FAIL mem_31_30 got=%0d/%0d/%b exp=30/0/10", bus0.mem_diag, bus0.mem_pu, bus0.mem_pe);
        end
        checks++;
        if (bus1.mem_diag !== 5'd30 || bus1.mem_pu !== 4'd0 || bus1.mem_pe !== 4'b1110) begin
            errors++; $display("FAIL mem64_63_62 got=%0d/%0d/%b exp=30/0/1110", bus1.mem_diag, bus1.mem_pu, bus1.mem_pe);
        end
    endtask

    task automatic test_back_to_back();
        run_job(3, 20, 0, "backpressure");
        run_job(2, 1, 1, "stray_load");
        run_job(0, 0, 0, "back_to_back");
    endtask

    task automatic test_reparam();
        rst1 = 1; step(); rst1 = 0;
        checks++;
        if (bus1.ready !== 1'b1 || bus1.busy !== 1'b0) begin
            errors++; $display("FAIL p64_reset got=%b%b exp=10", bus1.ready, bus1.busy);
        end
        bus1.start = 1; step(); bus1.start = 0;
        for (int n = 1; n <= 42; n++) begin
            if (n == 9 || n == 24 || n == 25 || n == 39) begin
                logic [15:0] want;
                want = (n == 24) ? 16'hFFFF : (n == 25) ? 16'h7FFF : 16'h0001;
                checks++;
                if (bus1.pu_wr_en[15:0] !== want || bus1.wave_idx !== 5'(n - 9)) begin
                    errors++; $display("FAIL p64_sweep cyc=%0d got=%h/%0d exp=%h/%0d", n, bus1.pu_wr_en, bus1.wave_idx, want, n - 9);
                end
            end
            if (n == 40) begin
                checks++;
                if (bus1.max_wr_en !== 1'b1 || bus1.pu_wr_en !== 16'h0) begin
                    errors++; $display("FAIL p64_drain got=%b/%h exp=1/0000", bus1.max_wr_en, bus1.pu_wr_en);
                end
            end
            if (n >= 41) begin
                checks++;
                if (bus1.tb_en !== 1'b1 || bus1.tb_start !== (n == 41)) begin
                    errors++; $display("FAIL p64_trace cyc=%0d got=%b%b", n, bus1.tb_en, bus1.tb_start);
                end
            end
            if (n < 42) step();
        end
        rst1 = 1; step(); rst1 = 0;
        checks++;
        if (bus1.tb_en !== 1'b0 || bus1.ready !== 1'b1 || bus1.busy !== 1'b0) begin
            errors++; $display("FAIL p64_rst_trace got=%b%b%b exp=010", bus1.tb_en, bus1.ready, bus1.busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 3000; n++) begin
            int r, c, d;
            rst              = ($urandom_range(0, 299) == 0);
            bus0.start       = ($urandom_range(0, 3) == 0);
            bus0.abort       = ($urandom_range(0, 255) == 0);
            bus0.tb_finished = ($urandom_range(0, 5) == 0);
            bus0.out_ready   = ($urandom_range(0, 3) == 0);
            bus0.tb_row      = 5'($urandom);
            bus0.tb_col      = 5'($urandom);
            step();
            checks++;
            if (obs0() !== exp_vec()) begin
                errors++; $display("FAIL random cyc=%0d got=%h exp=%h", n, obs0(), exp_vec());
            end
            r = int'(bus0.tb_row);
            c = int'(bus0.tb_col);
            d = r / 2 + c / 2;
            checks++;
            if (bus0.mem_diag !== 5'(d) || bus0.mem_pu !== 4'((d < NP) ? c / 2 : NP - 1 - r / 2) ||
                bus0.mem_pe !== 2'((r % 2) * 2 + c % 2)) begin
                errors++; $display("FAIL random_mem row=%0d col=%0d got=%0d/%0d/%b", r, c, bus0.mem_diag, bus0.mem_pu, bus0.mem_pe);
            end
        end
        rst = 0;
        clear_inputs();
    endtask

    initial begin
        clk = 0; rst = 1; rst1 = 1;
        checks = 0; errors = 0; m_age = 0; m_done = 0;
        clear_inputs();
        bus0.tb_row = 0; bus0.tb_col = 0;
        bus1.start = 0; bus1.abort = 0; bus1.tb_finished = 0; bus1.out_ready = 0;
        bus1.tb_row = 0; bus1.tb_col = 0;
        test_reset();
        test_nominal();
        test_abort();
        test_mem_select();
        test_back_to_back();
        test_reparam();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
